// File: rtl/bfly_pkg.sv
// Shared width derivations, rounding constants and output narrowing for bfly_r2_pipe.
// Define BFLY_SAT_EN to make sat_narrow clamp; otherwise it wraps.
package bfly_pkg;

    function automatic int prod_w(input int in_bit, input int tw_bit);
        return in_bit + tw_bit + 1;
    endfunction

    function automatic int resc_w(input int in_bit);
        return in_bit + 2;
    endfunction

    function automatic int sum_w(input int in_bit);
        return in_bit + 3;
    endfunction

    // Half an LSB of the Q1.(TW_BIT-1) product, for round-half-up rescale
    function automatic int tw_rnd(input int tw_bit);
        return 1 << (tw_bit - 2);
    endfunction

    localparam int SCALE_RND = 1;

    typedef struct packed {
        logic              ovf;
        logic signed [31:0] val;
    } narrow_t;

    function automatic narrow_t sat_narrow(input logic signed [31:0] v, input int out_bit);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        narrow_t            r;
        hi    = (32'sd1 <<< (out_bit - 1)) - 32'sd1;
        lo    = -hi - 32'sd1;
        r.ovf = (v > hi) || (v < lo);
        r.val = v;
`ifdef BFLY_SAT_EN
        if (v > hi)      r.val = hi;
        else if (v < lo) r.val = lo;
`endif
        return r;
    endfunction

endpackage

// File: rtl/bfly_r2_pipe_cmul.sv
// One lane's complex multiply W*B, rescaled with round-half-up and registered (stage S2).
module bfly_cmul
    import bfly_pkg::*;
#(
    parameter  int IN_BIT = 14,
    parameter  int TW_BIT = 16,
    localparam int PW     = prod_w(IN_BIT, TW_BIT),
    localparam int RW     = resc_w(IN_BIT)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     en_i,
    input  logic signed [IN_BIT-1:0] b_re_i,
    input  logic signed [IN_BIT-1:0] b_im_i,
    input  logic signed [TW_BIT-1:0] w_re_i,
    input  logic signed [TW_BIT-1:0] w_im_i,
    output logic signed [RW-1:0]     pr_o,
    output logic signed [RW-1:0]     pq_o
);
    localparam logic signed [PW-1:0] RND = PW'(tw_rnd(TW_BIT));

    logic signed [PW-1:0] pr_full, pq_full, pr_rnd, pq_rnd;
    logic signed [RW-1:0] pr_d, pq_d, pr_q, pq_q;

    assign pr_full = PW'(b_re_i) * PW'(w_re_i) - PW'(b_im_i) * PW'(w_im_i);
    assign pq_full = PW'(b_re_i) * PW'(w_im_i) + PW'(b_im_i) * PW'(w_re_i);
    assign pr_rnd  = pr_full + RND;
    assign pq_rnd  = pq_full + RND;
    // Top RW bits above the TW_BIT-1 fraction bits are exactly the shifted result
    assign pr_d    = pr_rnd[TW_BIT-1 +: RW];
    assign pq_d    = pq_rnd[TW_BIT-1 +: RW];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pr_q <= '0;
            pq_q <= '0;
        end else if (en_i) begin
            pr_q <= pr_d;
            pq_q <= pq_d;
        end
    end

    assign pr_o = pr_q;
    assign pq_o = pq_q;
endmodule

// File: rtl/bfly_r2_pipe.sv
// Three-stage N-lane radix-2 DIT butterfly (X = A + W*B, Y = A - W*B) with stall-able handshake.
// BFLY_SAT_EN selects saturating output narrowing (default: wrap); ovf is sticky in both builds.
module bfly_r2_pipe
    import bfly_pkg::*;
#(
    parameter int N       = 16,
    parameter int IN_BIT  = 14,
    parameter int TW_BIT  = 16,
    parameter int OUT_BIT = 17
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           scale,
    input  logic [N-1:0][IN_BIT-1:0]       din1_i,
    input  logic [N-1:0][IN_BIT-1:0]       din1_q,
    input  logic [N-1:0][IN_BIT-1:0]       din2_i,
    input  logic [N-1:0][IN_BIT-1:0]       din2_q,
    input  logic [N-1:0][TW_BIT-1:0]       tw_i,
    input  logic [N-1:0][TW_BIT-1:0]       tw_q,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N-1:0][OUT_BIT-1:0]      dout1_i,
    output logic [N-1:0][OUT_BIT-1:0]      dout1_q,
    output logic [N-1:0][OUT_BIT-1:0]      dout2_i,
    output logic [N-1:0][OUT_BIT-1:0]      dout2_q,
    output logic                           ovf,
    input  logic                           ovf_clr
);
    localparam int RW = resc_w(IN_BIT);
    localparam int SW = sum_w(IN_BIT);
    localparam logic signed [SW-1:0] ONE = SW'(SCALE_RND);

    logic                        adv;
    logic [3:1]                  vld_q;
    logic                        scale1_q, scale2_q;
    logic [N-1:0][IN_BIT-1:0]    a_i1_q, a_q1_q, b_i1_q, b_q1_q, a_i2_q, a_q2_q;
    logic [N-1:0][TW_BIT-1:0]    w_i1_q, w_q1_q;
    logic [N-1:0][RW-1:0]        pr2, pq2;
    logic [N-1:0][OUT_BIT-1:0]   x_i_d, x_q_d, y_i_d, y_q_d;
    logic [N-1:0][OUT_BIT-1:0]   x_i_q, x_q_q, y_i_q, y_q_q;
    logic [N-1:0]                lane_ovf;
    logic                        ovf_q, ovf_d;

    // Every stage shares one enable, so a stall freezes the whole pipe at once
    assign adv       = !vld_q[3] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[3];
    assign ovf_d     = (ovf_q && !ovf_clr) || (adv && vld_q[2] && |lane_ovf);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q    <= '0;
            scale1_q <= 1'b0;
            scale2_q <= 1'b0;
            a_i1_q   <= '0;
            a_q1_q   <= '0;
            b_i1_q   <= '0;
            b_q1_q   <= '0;
            w_i1_q   <= '0;
            w_q1_q   <= '0;
            a_i2_q   <= '0;
            a_q2_q   <= '0;
            x_i_q    <= '0;
            x_q_q    <= '0;
            y_i_q    <= '0;
            y_q_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            if (adv) begin
                vld_q    <= {vld_q[2:1], in_valid};
                scale1_q <= scale;
                scale2_q <= scale1_q;
                a_i1_q   <= din1_i;
                a_q1_q   <= din1_q;
                b_i1_q   <= din2_i;
                b_q1_q   <= din2_q;
                w_i1_q   <= tw_i;
                w_q1_q   <= tw_q;
                a_i2_q   <= a_i1_q;
                a_q2_q   <= a_q1_q;
                x_i_q    <= x_i_d;
                x_q_q    <= x_q_d;
                y_i_q    <= y_i_d;
                y_q_q    <= y_q_d;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        logic signed [SW-1:0] sum [4];
        logic signed [SW-1:0] scl [4];
        narrow_t              nr  [4];

        bfly_cmul #(.IN_BIT(IN_BIT), .TW_BIT(TW_BIT)) u_cmul (
            .clk    (clk),
            .rstn   (rstn),
            .en_i   (adv),
            .b_re_i (b_i1_q[g]),
            .b_im_i (b_q1_q[g]),
            .w_re_i (w_i1_q[g]),
            .w_im_i (w_q1_q[g]),
            .pr_o   (pr2[g]),
            .pq_o   (pq2[g])
        );

        // Components ordered X_i, X_q, Y_i, Y_q
        always_comb begin
            sum[0] = SW'($signed(a_i2_q[g])) + SW'($signed(pr2[g]));
            sum[1] = SW'($signed(a_q2_q[g])) + SW'($signed(pq2[g]));
            sum[2] = SW'($signed(a_i2_q[g])) - SW'($signed(pr2[g]));
            sum[3] = SW'($signed(a_q2_q[g])) - SW'($signed(pq2[g]));
            for (int c = 0; c < 4; c++) begin
                scl[c] = scale2_q ? ((sum[c] + ONE) >>> 1) : sum[c];
                nr[c]  = sat_narrow(32'(scl[c]), OUT_BIT);
            end
        end

        assign x_i_d[g]    = nr[0].val[OUT_BIT-1:0];
        assign x_q_d[g]    = nr[1].val[OUT_BIT-1:0];
        assign y_i_d[g]    = nr[2].val[OUT_BIT-1:0];
        assign y_q_d[g]    = nr[3].val[OUT_BIT-1:0];
        assign lane_ovf[g] = nr[0].ovf | nr[1].ovf | nr[2].ovf | nr[3].ovf;
    end

    assign dout1_i = x_i_q;
    assign dout1_q = x_q_q;
    assign dout2_i = y_i_q;
    assign dout2_q = y_q_q;
    assign ovf     = ovf_q;
endmodule

// File: tb/tb_bfly_r2_pipe.sv
// Directed bench for bfly_r2_pipe: default-width instance plus a narrow OUT_BIT=14 instance for overflow.
module tb_bfly_r2_pipe;
    localparam int N = 16, IB = 14, TB = 16, OB = 17;
    localparam int SN = 2, SOB = 14;
`ifdef BFLY_SAT_EN
    localparam int SAT_X = 8191;
`else
    localparam int SAT_X = -2;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic in_valid, in_ready, scale, out_valid, out_ready, ovf, ovf_clr;
    logic [N-1:0][IB-1:0] din1_i, din1_q, din2_i, din2_q;
    logic [N-1:0][TB-1:0] tw_i, tw_q;
    logic [N-1:0][OB-1:0] dout1_i, dout1_q, dout2_i, dout2_q, frz;

    logic s_in_valid, s_in_ready, s_scale, s_out_valid, s_out_ready, s_ovf, s_ovf_clr;
    logic [SN-1:0][IB-1:0]  s_din1_i, s_din1_q, s_din2_i, s_din2_q;
    logic [SN-1:0][TB-1:0]  s_tw_i, s_tw_q;
    logic [SN-1:0][SOB-1:0] s_dout1_i, s_dout1_q, s_dout2_i, s_dout2_q;

    int pass_cnt = 0;
    int total_cnt = 0;

    bfly_r2_pipe #(.N(N), .IN_BIT(IB), .TW_BIT(TB), .OUT_BIT(OB)) u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .scale(scale),
        .din1_i(din1_i), .din1_q(din1_q), .din2_i(din2_i), .din2_q(din2_q),
        .tw_i(tw_i), .tw_q(tw_q), .out_valid(out_valid), .out_ready(out_ready),
        .dout1_i(dout1_i), .dout1_q(dout1_q), .dout2_i(dout2_i), .dout2_q(dout2_q),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    bfly_r2_pipe #(.N(SN), .IN_BIT(IB), .TW_BIT(TB), .OUT_BIT(SOB)) u_sat (
        .clk(clk), .rstn(rstn), .in_valid(s_in_valid), .in_ready(s_in_ready), .scale(s_scale),
        .din1_i(s_din1_i), .din1_q(s_din1_q), .din2_i(s_din2_i), .din2_q(s_din2_q),
        .tw_i(s_tw_i), .tw_q(s_tw_q), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .dout1_i(s_dout1_i), .dout1_q(s_dout1_q), .dout2_i(s_dout2_i), .dout2_q(s_dout2_q),
        .ovf(s_ovf), .ovf_clr(s_ovf_clr)
    );

    function automatic logic [N-1:0][OB-1:0] rep(input int v);
        logic [OB-1:0] e;
        e = OB'(v);
        return {N{e}};
    endfunction

    function automatic logic [SN-1:0][SOB-1:0] srep(input int v);
        logic [SOB-1:0] e;
        e = SOB'(v);
        return {SN{e}};
    endfunction

    task automatic drive(input int ai, input int aq, input int bi, input int bq,
                         input int wi, input int wq, input logic sc);
        logic [IB-1:0] e1i, e1q, e2i, e2q;
        logic [TB-1:0] ewi, ewq;
        e1i = IB'(ai); e1q = IB'(aq); e2i = IB'(bi); e2q = IB'(bq);
        ewi = TB'(wi); ewq = TB'(wq);
        din1_i = {N{e1i}}; din1_q = {N{e1q}}; din2_i = {N{e2i}}; din2_q = {N{e2q}};
        tw_i = {N{ewi}}; tw_q = {N{ewq}}; scale = sc;
    endtask

    // A=B=(8191,0), W~1: X=16382 overflows 14 bits, Y=0
    task automatic sdrive_ovf;
        logic [IB-1:0] e;
        logic [TB-1:0] w;
        e = IB'(8191); w = TB'(32767);
        s_din1_i = {SN{e}}; s_din2_i = {SN{e}}; s_din1_q = '0; s_din2_q = '0;
        s_tw_i = {SN{w}}; s_tw_q = '0; s_scale = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else pass_cnt++;
        total_cnt++; if (dout1_i !== rep(0)) $display("FAIL reset_dout1_i got %h exp 0", dout1_i); else pass_cnt++;
        total_cnt++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b exp 0", ovf); else pass_cnt++;
        rstn = 1'b1;
    endtask

    task automatic test_unity;
        @(negedge clk); drive(100, 0, 1000, 0, 32767, 0, 1'b0); in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL unity_latency got %b exp 0", out_valid); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL unity_valid got %b exp 1", out_valid); else pass_cnt++;
        total_cnt++; if (dout1_i !== rep(1100)) $display("FAIL unity_x_i got %h exp %h", dout1_i, rep(1100)); else pass_cnt++;
        total_cnt++; if (dout1_q !== rep(0)) $display("FAIL unity_x_q got %h exp %h", dout1_q, rep(0)); else pass_cnt++;
        total_cnt++; if (dout2_i !== rep(-900)) $display("FAIL unity_y_i got %h exp %h", dout2_i, rep(-900)); else pass_cnt++;
        total_cnt++; if (dout2_q !== rep(0)) $display("FAIL unity_y_q got %h exp %h", dout2_q, rep(0)); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL unity_bubble got %b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_negj;
        @(negedge clk); drive(0, 0, 200, 50, 0, -32768, 1'b0); in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (dout1_i !== rep(50)) $display("FAIL negj_x_i got %h exp %h", dout1_i, rep(50)); else pass_cnt++;
        total_cnt++; if (dout1_q !== rep(-200)) $display("FAIL negj_x_q got %h exp %h", dout1_q, rep(-200)); else pass_cnt++;
        total_cnt++; if (dout2_i !== rep(-50)) $display("FAIL negj_y_i got %h exp %h", dout2_i, rep(-50)); else pass_cnt++;
        total_cnt++; if (dout2_q !== rep(200)) $display("FAIL negj_y_q got %h exp %h", dout2_q, rep(200)); else pass_cnt++;
    endtask

    task automatic test_scale;
        @(negedge clk); drive(3, -3, 0, 0, 0, 0, 1'b1); in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0; scale = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (dout1_i !== rep(2)) $display("FAIL scale_x_i got %h exp %h", dout1_i, rep(2)); else pass_cnt++;
        total_cnt++; if (dout1_q !== rep(-1)) $display("FAIL scale_x_q got %h exp %h", dout1_q, rep(-1)); else pass_cnt++;
        total_cnt++; if (dout2_i !== rep(2)) $display("FAIL scale_y_i got %h exp %h", dout2_i, rep(2)); else pass_cnt++;
        total_cnt++; if (dout2_q !== rep(-1)) $display("FAIL scale_y_q got %h exp %h", dout2_q, rep(-1)); else pass_cnt++;
    endtask

    // Beat k: A_i[l]=100k+l, A_q=-k, B=(k+1,0), W~1 -> X_i=A_i+k+1, Y_i=A_i-k-1
    task automatic test_back_to_back;
        int tx, rx;
        logic [N-1:0][OB-1:0] e1, e2;
        tx = 0; rx = 0;
        drive(0, 0, 0, 0, 32767, 0, 1'b0);
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc <= 10);
            in_valid  = (tx < 8);
            for (int l = 0; l < N; l++) begin
                din1_i[l] = IB'(tx * 100 + l);
                din1_q[l] = IB'(-tx);
                din2_i[l] = IB'(tx + 1);
            end
            #1;
            if (cyc >= 6 && cyc <= 10) begin
                total_cnt++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || (cyc > 6 && dout1_i !== frz))
                    $display("FAIL stall_hold cyc %0d in_ready %b out_valid %b dout1_i %h exp %h",
                             cyc, in_ready, out_valid, dout1_i, frz);
                else pass_cnt++;
                if (cyc == 6) frz = dout1_i;
            end
            if (out_valid && out_ready) begin
                for (int l = 0; l < N; l++) begin
                    e1[l] = OB'(rx * 100 + l + rx + 1);
                    e2[l] = OB'(rx * 100 + l - rx - 1);
                end
                total_cnt++; if (dout1_i !== e1) $display("FAIL stream_x_i beat %0d got %h exp %h", rx, dout1_i, e1); else pass_cnt++;
                total_cnt++; if (dout2_i !== e2) $display("FAIL stream_y_i beat %0d got %h exp %h", rx, dout2_i, e2); else pass_cnt++;
                rx++;
            end
            if (in_valid && in_ready) tx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total_cnt++; if (rx !== 8) $display("FAIL stream_count got %0d exp 8", rx); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL stream_drained got %b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_saturation;
        @(negedge clk); sdrive_ovf(); s_in_valid = 1'b1;
        @(negedge clk); s_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (s_dout1_i !== srep(SAT_X)) $display("FAIL sat_x_i got %h exp %h", s_dout1_i, srep(SAT_X)); else pass_cnt++;
        total_cnt++; if (s_dout2_i !== srep(0)) $display("FAIL sat_y_i got %h exp %h", s_dout2_i, srep(0)); else pass_cnt++;
        total_cnt++; if (s_ovf !== 1'b1) $display("FAIL sat_ovf got %b exp 1", s_ovf); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (s_ovf !== 1'b1) $display("FAIL sat_ovf_sticky got %b exp 1", s_ovf); else pass_cnt++;
        s_ovf_clr = 1'b1;
        @(negedge clk); s_ovf_clr = 1'b0;
        total_cnt++; if (s_ovf !== 1'b0) $display("FAIL sat_ovf_clr got %b exp 0", s_ovf); else pass_cnt++;
        // clear coinciding with a fresh overflow load: set must win
        s_in_valid = 1'b1;
        @(negedge clk); s_in_valid = 1'b0;
        @(negedge clk); s_ovf_clr = 1'b1;
        total_cnt++; if (s_ovf !== 1'b0) $display("FAIL sat_ovf_early got %b exp 0", s_ovf); else pass_cnt++;
        @(negedge clk); s_ovf_clr = 1'b0;
        total_cnt++; if (s_ovf !== 1'b1) $display("FAIL sat_set_wins got %b exp 1", s_ovf); else pass_cnt++;
        total_cnt++; if (ovf !== 1'b0) $display("FAIL wide_no_ovf got %b exp 0", ovf); else pass_cnt++;
    endtask

    task automatic test_reset_midstream;
        logic bad;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive((k + 1) * 10, 0, 0, 0, 0, 0, 1'b0); in_valid = 1'b1;
            if (k == 0) sdrive_ovf();
            s_in_valid = (k == 0);
        end
        @(negedge clk); in_valid = 1'b0; s_in_valid = 1'b0;
        total_cnt++; if (out_valid !== 1'b1 || s_ovf !== 1'b1) $display("FAIL rst_pre out_valid %b ovf %b exp 1 1", out_valid, s_ovf); else pass_cnt++;
        rstn = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (dout1_i !== rep(0)) $display("FAIL rst_dout1_i got %h exp 0", dout1_i); else pass_cnt++;
        total_cnt++; if (s_ovf !== 1'b0) $display("FAIL rst_ovf got %b exp 0", s_ovf); else pass_cnt++;
        total_cnt++; if (s_dout1_i !== srep(0)) $display("FAIL rst_sat_dout got %h exp 0", s_dout1_i); else pass_cnt++;
        @(negedge clk); rstn = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
        end
        total_cnt++; if (bad !== 1'b0) $display("FAIL rst_no_stale got %b exp 0", bad); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1'b0);
        frz = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b1; s_ovf_clr = 1'b0; s_scale = 1'b0;
        s_din1_i = '0; s_din1_q = '0; s_din2_i = '0; s_din2_q = '0; s_tw_i = '0; s_tw_q = '0;
        test_reset();
        test_unity();
        test_negj();
        test_scale();
        test_back_to_back();
        test_saturation();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
